// File: rtl/operand_fetch_if.sv
// operand_fetch_if: request strobe, memory read ports and assembled vector outputs
interface operand_fetch_if #(
  parameter int N = 32,
  parameter int W = 8
);
  localparam int IW = $clog2(N);
  localparam int AW = 2 * IW;
  logic                  new_request;
  logic [IW-1:0]         row_req;
  logic [IW-1:0]         col_req;
  logic [AW-1:0]         a_addr;
  logic [W-1:0]          a_data;
  logic [AW-1:0]         b_addr;
  logic [W-1:0]          b_data;
  logic [N-1:0][W-1:0]   matA_row;
  logic [N-1:0][W-1:0]   matB_col;
  logic [IW-1:0]         row_in;
  logic [IW-1:0]         col_in;
  logic                  val_rows;
  logic                  busy;
  modport master (
    output new_request, row_req, col_req, a_data, b_data,
    input  a_addr, b_addr, matA_row, matB_col, row_in, col_in, val_rows, busy
  );
  modport slave (
    input  new_request, row_req, col_req, a_data, b_data,
    output a_addr, b_addr, matA_row, matB_col, row_in, col_in, val_rows, busy
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: streams an A row and a B column from two latency-LAT memories into packed N-lane vectors
module operand_fetch #(
  parameter int N   = 32,
  parameter int W   = 8,
  parameter int LAT = 2
) (
  input logic           clk_in,
  input logic           rst_in,
  operand_fetch_if.slave bus
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, PRESENT} state_t;
  state_t                 state, state_nx;
  logic [IW-1:0]          k;
  logic [LAT-1:0]         vld, vld_sh;
  logic [LAT-1:0][IW-1:0] tag;
  logic                   accept, push, last, drain_done;
  always_ff @(posedge clk_in) state <= !rst_in ? IDLE : state_nx;
  always_comb begin
    state_nx = accept ? ISSUE :
               state == ISSUE ? (last ? DRAIN : ISSUE) :
               state == DRAIN ? (drain_done ? PRESENT : DRAIN) : IDLE;
  end
  // the oldest tag is written this cycle, so only the younger stages must be empty to leave DRAIN
  assign vld_sh = vld << 1;
  always_comb begin
    accept       = bus.new_request && (state == IDLE || state == PRESENT);
    push         = state == ISSUE;
    last         = k == IW'(N - 1);
    drain_done   = vld_sh == '0;
    bus.val_rows = state == PRESENT;
    bus.busy     = push || state == DRAIN;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      k            <= '0;
      vld          <= '0;
      tag          <= '0;
      bus.a_addr   <= '0;
      bus.b_addr   <= '0;
      bus.row_in   <= '0;
      bus.col_in   <= '0;
      bus.matA_row <= '0;
      bus.matB_col <= '0;
    end else begin
      vld[0] <= push;
      tag[0] <= k;
      for (int i = 1; i < LAT; i++) begin
        vld[i] <= vld[i-1];
        tag[i] <= tag[i-1];
      end
      if (vld[LAT-1]) begin
        bus.matA_row[tag[LAT-1]] <= bus.a_data;
        bus.matB_col[tag[LAT-1]] <= bus.b_data;
      end
      // address for k=0 is loaded on accept so each address leads its ISSUE cycle's tag
      if (accept) begin
        k          <= '0;
        bus.row_in <= bus.row_req;
        bus.col_in <= bus.col_req;
        bus.a_addr <= {bus.row_req, IW'(0)};
        bus.b_addr <= {IW'(0), bus.col_req};
      end else if (push) begin
        k <= k + 1'b1;
        if (!last) begin
          bus.a_addr <= {bus.row_in, k + 1'b1};
          bus.b_addr <= {k + 1'b1, bus.col_in};
        end
      end
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: scoreboard bench driving LAT=2 and LAT=1 instances with the same request stream
module tb_operand_fetch;
  localparam int N = 32;
  localparam int W = 8;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       new_request = 1;
  logic [4:0] row_req = 0;
  logic [4:0] col_req = 0;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  bit         done = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, int g, logic [N*W-1:0] got, logic [N*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", name, g, cyc, got, exp);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = g == 0 ? 2 : 1;
    typedef struct packed {logic [4:0] r; logic [4:0] c;} vec_t;
    typedef struct {int cy; int a; int b;} ad_t;
    operand_fetch_if #(.N(N), .W(W)) bus ();
    logic [W-1:0] pa [L];
    logic [W-1:0] pb [L];
    vec_t q [$];
    ad_t  aq [$];
    bit   ready = 0, prev_rst = 0, active = 0, fin = 0;
    int   acc = 0, pres = 0;
    assign bus.new_request = new_request;
    assign bus.row_req     = row_req;
    assign bus.col_req     = col_req;
    assign bus.a_data      = pa[L-1];
    assign bus.b_data      = pb[L-1];
    always @(posedge clk) begin
      pa[0] <= bus.a_addr[7:0];
      pb[0] <= bus.b_addr[7:0] ^ 8'h55;
      for (int i = 1; i < L; i++) begin
        pa[i] <= pa[i-1];
        pb[i] <= pb[i-1];
      end
    end
    operand_fetch #(.N(N), .W(W), .LAT(L)) dut (
      .clk_in(clk),
      .rst_in(rst_n),
      .bus   (bus)
    );
    always @(negedge clk) begin
      automatic logic [N*W-1:0] ea, eb;
      automatic vec_t e;
      if (ready) begin
        check("val_rows", g, bus.val_rows, active && cyc == pres);
        check("busy", g, bus.busy, active && cyc > acc && cyc < pres);
        if (prev_rst) begin
          check("rst_a_addr", g, bus.a_addr, 0);
          check("rst_b_addr", g, bus.b_addr, 0);
          check("rst_row_in", g, bus.row_in, 0);
          check("rst_col_in", g, bus.col_in, 0);
          check("rst_matA", g, bus.matA_row, 0);
          check("rst_matB", g, bus.matB_col, 0);
        end
        if (bus.val_rows) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_val_rows dut%0d cycle %0d: got pulse expected none", g, cyc);
          end else begin
            e = q.pop_front();
            for (int k = 0; k < N; k++) begin
              ea[k*W +: W] = W'(e.r * 32 + k);
              eb[k*W +: W] = W'(k * 32 + e.c) ^ 8'h55;
            end
            check("row_in", g, bus.row_in, e.r);
            check("col_in", g, bus.col_in, e.c);
            check("matA_row", g, bus.matA_row, ea);
            check("matB_col", g, bus.matB_col, eb);
          end
        end
        while (aq.size() > 0 && aq[0].cy < cyc) begin
          checks++;
          failures++;
          $display("FAIL addr_missed dut%0d cycle %0d: got nothing expected a=%0d b=%0d", g, cyc, aq[0].a, aq[0].b);
          void'(aq.pop_front());
        end
        if (aq.size() > 0 && aq[0].cy == cyc) begin
          check("a_addr", g, bus.a_addr, aq[0].a);
          check("b_addr", g, bus.b_addr, aq[0].b);
          void'(aq.pop_front());
        end
      end
      prev_rst = !rst_n;
      if (!rst_n) begin
        ready  = 1;
        active = 0;
        q.delete();
        aq.delete();
      end else if (new_request && (!active || cyc >= pres)) begin
        active = 1;
        acc    = cyc;
        pres   = cyc + N + L + 1;
        q.push_back('{row_req, col_req});
        for (int k = 0; k < N; k++) aq.push_back('{cyc + 1 + k, row_req * 32 + k, k * 32 + col_req});
      end
      if (done && !fin) begin
        fin = 1;
        check("queue_empty", g, q.size() + aq.size(), 0);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [4:0] r, input logic [4:0] c);
    row_req     = r;
    col_req     = c;
    new_request = 1;
    tick();
    new_request = 0;
  endtask
  initial begin
    repeat (2) tick();
    rst_n       = 1;
    new_request = 0;
    repeat (5) tick();
    req(3, 7);
    repeat (40) tick();
    req(31, 31);
    repeat (40) tick();
    req(0, 0);
    repeat (40) tick();
    req(2, 9);
    repeat (9) tick();
    req(5, 5);
    repeat (9) tick();
    req(5, 5);
    repeat (60) tick();
    req(2, 9);
    repeat (34) tick();
    req(4, 1);
    repeat (80) tick();
    req(3, 3);
    repeat (11) tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    repeat (5) tick();
    req(6, 6);
    repeat (40) tick();
    done = 1;
    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
